cdec8_cu: RTL and testbench

- Control unit (microsequencer) for the CDEC8 8-bit CPU. It sits directly upstream of the CDEC8 data path.
- Consumes the instruction register I[7:0] and the flags SZCy[2:0] from the data path.
- Produces the 15-bit per-cycle control word ctrl = {mmrw[1:0], fwr, rwr, xdst[2:0], aluop[4:0], xsrc[2:0]} that steers XBUS, the register loads, the ALU and memory.
- Moore FSM: fetch, decode, operand fetch, execute.

---
 rtl/cdec8_pkg.sv | 40 ++++
 rtl/cdec8_cu_if.sv | 18 +
 rtl/cdec8_cond_eval.sv | 14 +
 rtl/cdec8_cu.sv | 111 +++++++++++
 tb/tb_cdec8_cu.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdec8_pkg.sv
// cdec8_pkg: shared state, register, ALU and opcode codes for the CDEC8 control unit
package cdec8_pkg;
  typedef enum logic [3:0] {
    ST_RST = 4'h0, ST_F0 = 4'h1, ST_F1 = 4'h2, ST_F2 = 4'h3, ST_D = 4'h4,
    ST_O0 = 4'h5, ST_O1 = 4'h6, ST_O2 = 4'h7, ST_E0 = 4'h8, ST_E1 = 4'h9,
    ST_HALT = 4'hF
  } state_t;
  localparam logic [2:0] XS_PC = 3'd0, XS_A = 3'd1, XS_B = 3'd2, XS_C = 3'd3,
                         XS_R = 3'd4, XS_RDR = 3'd5, XS_FLG = 3'd6, XS_FF = 3'd7;
  localparam logic [2:0] XD_PC = 3'd0, XD_A = 3'd1, XD_B = 3'd2, XD_C = 3'd3,
                         XD_MAR = 3'd4, XD_WDR = 3'd5, XD_T = 3'd6, XD_I = 3'd7;
  localparam logic [1:0] MM_NONE = 2'b00, MM_WR = 2'b01, MM_RD = 2'b10;
  localparam logic [4:0] ALU_THR = 5'h00, ALU_INC = 5'h01, ALU_ADD = 5'h04, ALU_SUB = 5'h05,
                         ALU_AND = 5'h06, ALU_OR = 5'h07, ALU_EOR = 5'h08;
  localparam logic [3:0] OP_NOP = 4'h0, OP_LDI = 4'h1, OP_LD = 4'h2, OP_ST = 4'h3,
                         OP_ADD = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR = 4'h7,
                         OP_EOR = 4'h8, OP_CMP = 4'h9, OP_JMP = 4'hA, OP_BCC = 4'hB,
                         OP_HLT = 4'hF;
  localparam logic [3:0] CC_AL = 4'd0, CC_Z = 4'd1, CC_NZ = 4'd2, CC_C = 4'd3,
                         CC_NC = 4'd4, CC_S = 4'd5, CC_NS = 4'd6;
  typedef struct packed {
    logic [1:0] mmrw;
    logic       fwr;
    logic       rwr;
    logic [2:0] xdst;
    logic [4:0] aluop;
    logic [2:0] xsrc;
  } ctrl_t;
  localparam ctrl_t CTRL_IDLE = '{mmrw: MM_NONE, fwr: 1'b0, rwr: 1'b0, xdst: XD_T, aluop: ALU_THR, xsrc: XS_FF};
  localparam ctrl_t CTRL_ADR  = '{mmrw: MM_NONE, fwr: 1'b0, rwr: 1'b1, xdst: XD_MAR, aluop: ALU_INC, xsrc: XS_PC};
  localparam ctrl_t CTRL_RD   = '{mmrw: MM_RD, fwr: 1'b0, rwr: 1'b0, xdst: XD_PC, aluop: ALU_THR, xsrc: XS_R};
  function automatic logic [4:0] alu_of(input logic [3:0] op);
    return op == OP_ADD ? ALU_ADD : op == OP_AND ? ALU_AND : op == OP_OR ? ALU_OR :
           op == OP_EOR ? ALU_EOR : ALU_SUB;
  endfunction
  // ra=11 aliases A
  function automatic logic [2:0] reg_of(input logic [1:0] ra);
    return ra == 2'b11 ? XS_A : {1'b0, ra} + 3'd1;
  endfunction
endpackage

// File: rtl/cdec8_cu_if.sv
// cdec8_cu_if: control unit <-> data path bundle; step exists only with CDEC8_SINGLE_STEP_EN
interface cdec8_cu_if;
  import cdec8_pkg::*;
  logic [7:0] I;
  logic [2:0] SZCy;
  ctrl_t      ctrl;
  logic [3:0] state;
  logic       halt;
  logic       fetch;
`ifdef CDEC8_SINGLE_STEP_EN
  logic       step;
  modport master(input I, SZCy, step, output ctrl, state, halt, fetch);
  modport slave(output I, SZCy, step, input ctrl, state, halt, fetch);
`else
  modport master(input I, SZCy, output ctrl, state, halt, fetch);
  modport slave(output I, SZCy, input ctrl, state, halt, fetch);
`endif
endinterface

// File: rtl/cdec8_cond_eval.sv
// cdec8_cond_eval: branch condition code against live {S,Z,Cy} flags
module cdec8_cond_eval
  import cdec8_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [2:0] i_szcy,
  output logic       o_taken
);
  logic w_s, w_z, w_c;
  assign {w_s, w_z, w_c} = i_szcy;
  assign o_taken = i_cond == CC_AL ? 1'b1 : i_cond == CC_Z ? w_z : i_cond == CC_NZ ? !w_z :
                   i_cond == CC_C ? w_c : i_cond == CC_NC ? !w_c : i_cond == CC_S ? w_s :
                   i_cond == CC_NS ? !w_s : 1'b0;
endmodule

// File: rtl/cdec8_cu.sv
// cdec8_cu: CDEC8 Moore microsequencer (fetch/decode/operand/execute).
// Define CDEC8_SINGLE_STEP_EN to gate decode on a latched rising edge of step.
module cdec8_cu
  import cdec8_pkg::*;
#(
  parameter int RST_PC_CYC = 1
) (
  input logic          clock,
  input logic          reset,
  cdec8_cu_if.master   cu
);
  state_t     r_state, w_next;
  logic [3:0] r_cnt;
  ctrl_t      w_ctrl;
  logic [3:0] w_op;
  logic [2:0] w_ra;
  logic       w_alu, w_taken, w_go;
  assign w_op  = cu.I[7:4];
  assign w_ra  = reg_of(cu.I[3:2]);
  assign w_alu = w_op >= OP_ADD && w_op <= OP_CMP;
  cdec8_cond_eval u_cond (.i_cond(cu.I[3:0]), .i_szcy(cu.SZCy), .o_taken(w_taken));
`ifdef CDEC8_SINGLE_STEP_EN
  logic r_step_d, r_step_pend;
  // an edge seen during F0 itself still counts for the upcoming decode
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_step_d    <= 1'b0;
      r_step_pend <= 1'b0;
    end else begin
      r_step_d    <= cu.step;
      r_step_pend <= (cu.step & ~r_step_d) | (r_step_pend & (r_state != ST_F0));
    end
  assign w_go = r_step_pend;
`else
  assign w_go = 1'b1;
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state <= ST_RST;
      r_cnt   <= 4'(RST_PC_CYC);
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == ST_RST && r_cnt > 4'd1) ? r_cnt - 4'd1 : r_cnt;
    end
  always_comb begin
    w_next = r_state;
    w_ctrl = CTRL_IDLE;
    case (r_state)
      ST_RST: w_next = r_cnt <= 4'd1 ? ST_F0 : ST_RST;
      ST_F0: begin
        w_ctrl = CTRL_ADR;
        w_next = ST_F1;
      end
      ST_F1: begin
        w_ctrl = CTRL_RD;
        w_next = ST_F2;
      end
      ST_F2: begin
        w_ctrl.xsrc = XS_RDR;
        w_ctrl.xdst = XD_I;
        w_next = ST_D;
      end
      ST_D: w_next = !w_go ? ST_D : w_op == OP_HLT ? ST_HALT :
                     (w_op == OP_NOP || w_op > OP_BCC) ? ST_F0 : ST_O0;
      ST_O0: begin
        w_ctrl = CTRL_ADR;
        w_next = ST_O1;
      end
      ST_O1: begin
        w_ctrl = CTRL_RD;
        w_next = (w_op == OP_BCC && !w_taken) ? ST_F0 : ST_O2;
      end
      ST_O2: begin
        w_ctrl.xsrc = XS_RDR;
        w_ctrl.xdst = w_op == OP_LDI ? w_ra : (w_op == OP_LD || w_op == OP_ST) ? XD_MAR :
                      w_alu ? XD_T : XD_PC;
        w_next = (w_op == OP_LDI || w_op == OP_JMP || w_op == OP_BCC) ? ST_F0 : ST_E0;
      end
      ST_E0: begin
        w_next = w_op == OP_CMP ? ST_F0 : ST_E1;
        if (w_op == OP_LD) w_ctrl.mmrw = MM_RD;
        else if (w_op == OP_ST) begin
          w_ctrl.xsrc = w_ra;
          w_ctrl.xdst = XD_WDR;
        end else if (w_alu) begin
          w_ctrl.xsrc  = w_ra;
          w_ctrl.aluop = alu_of(w_op);
          w_ctrl.rwr   = 1'b1;
          w_ctrl.fwr   = 1'b1;
        end
      end
      ST_E1: begin
        w_next = ST_F0;
        if (w_op == OP_LD) begin
          w_ctrl.xsrc = XS_RDR;
          w_ctrl.xdst = w_ra;
        end else if (w_op == OP_ST) w_ctrl.mmrw = MM_WR;
        else if (w_alu) begin
          w_ctrl.xsrc = XS_R;
          w_ctrl.xdst = w_ra;
        end
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_RST;
    endcase
  end
  assign cu.ctrl  = w_ctrl;
  assign cu.state = r_state;
  assign cu.halt  = r_state == ST_HALT;
  assign cu.fetch = r_state == ST_F0;
endmodule

// File: tb/tb_cdec8_cu.sv
// tb_cdec8_cu: scoreboard bench; expected per-cycle (state, ctrl) queued per instruction
module tb_cdec8_cu;
  import cdec8_pkg::*;
  localparam int P = 3;
  localparam logic [14:0] IDLE = {2'b00, 1'b0, 1'b0, 3'b110, ALU_THR, 3'b111};
  localparam logic [14:0] F0W  = {2'b00, 1'b0, 1'b1, 3'b100, ALU_INC, 3'b000};
  localparam logic [14:0] F1W  = {2'b10, 1'b0, 1'b0, 3'b000, ALU_THR, 3'b100};
  typedef struct packed {logic [3:0] st; logic [14:0] ctrl;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  int errs = 0, checks = 0, wr_cnt = 0;
  exp_t sb[$];
  cdec8_cu_if cu();
  cdec8_cu #(.RST_PC_CYC(P)) dut (.clock(clk), .reset(rst), .cu(cu));
  always #5 clk = ~clk;
  always @(negedge clk) if (cu.ctrl[14:13] == 2'b01) wr_cnt++;
  function automatic logic [14:0] cw(input logic [1:0] m, input logic f, input logic r,
                                     input logic [2:0] d, input logic [4:0] a, input logic [2:0] s);
    return {m, f, r, d, a, s};
  endfunction
  function automatic logic [2:0] rc(input logic [1:0] ra);
    case (ra)
      2'd0: return 3'd1;
      2'd1: return 3'd2;
      2'd2: return 3'd3;
      default: return 3'd1;
    endcase
  endfunction
  function automatic logic [4:0] aluv(input logic [3:0] op);
    case (op)
      4'h4: return ALU_ADD;
      4'h6: return ALU_AND;
      4'h7: return ALU_OR;
      4'h8: return ALU_EOR;
      default: return ALU_SUB;
    endcase
  endfunction
  function automatic logic bt(input logic [3:0] c, input logic [2:0] f);
    case (c)
      4'd0: return 1'b1;
      4'd1: return f[1];
      4'd2: return !f[1];
      4'd3: return f[0];
      4'd4: return !f[0];
      4'd5: return f[2];
      4'd6: return !f[2];
      default: return 1'b0;
    endcase
  endfunction
  task automatic push(input logic [3:0] st, input logic [14:0] c);
    sb.push_back('{st: st, ctrl: c});
  endtask
  task automatic build(input logic [7:0] ins, input logic [2:0] f);
    logic [3:0] op;
    logic [2:0] r;
    op = ins[7:4];
    r = rc(ins[3:2]);
    push(4'd1, F0W);
    push(4'd2, F1W);
    push(4'd3, cw(2'b00, 1'b0, 1'b0, 3'b111, ALU_THR, 3'b101));
    push(4'd4, IDLE);
    if (op == 4'h0 || op >= 4'hC) return;
    push(4'd5, F0W);
    push(4'd6, F1W);
    if (op == 4'hB && !bt(ins[3:0], f)) return;
    case (op)
      4'h1: push(4'd7, cw(2'b00, 1'b0, 1'b0, r, ALU_THR, 3'b101));
      4'h2: begin
        push(4'd7, cw(2'b00, 1'b0, 1'b0, 3'b100, ALU_THR, 3'b101));
        push(4'd8, cw(2'b10, 1'b0, 1'b0, 3'b110, ALU_THR, 3'b111));
        push(4'd9, cw(2'b00, 1'b0, 1'b0, r, ALU_THR, 3'b101));
      end
      4'h3: begin
        push(4'd7, cw(2'b00, 1'b0, 1'b0, 3'b100, ALU_THR, 3'b101));
        push(4'd8, cw(2'b00, 1'b0, 1'b0, 3'b101, ALU_THR, r));
        push(4'd9, cw(2'b01, 1'b0, 1'b0, 3'b110, ALU_THR, 3'b111));
      end
      4'h9: begin
        push(4'd7, cw(2'b00, 1'b0, 1'b0, 3'b110, ALU_THR, 3'b101));
        push(4'd8, cw(2'b00, 1'b1, 1'b1, 3'b110, ALU_SUB, r));
      end
      4'hA, 4'hB: push(4'd7, cw(2'b00, 1'b0, 1'b0, 3'b000, ALU_THR, 3'b101));
      default: begin
        push(4'd7, cw(2'b00, 1'b0, 1'b0, 3'b110, ALU_THR, 3'b101));
        push(4'd8, cw(2'b00, 1'b1, 1'b1, 3'b110, aluv(op), r));
        push(4'd9, cw(2'b00, 1'b0, 1'b0, r, ALU_THR, 3'b100));
      end
    endcase
  endtask
  // entered just after a posedge with state F0; leaves the same way (or in HALT)
  task automatic run(input logic [7:0] ins, input logic [2:0] f, input string nm);
    exp_t e;
    int n = 0;
    logic [3:0] end_st;
    cu.I = ins;
    cu.SZCy = f;
    end_st = ins[7:4] == 4'hF ? 4'hF : 4'd1;
    build(ins, f);
    while (sb.size() > 0) begin
      e = sb.pop_front();
`ifdef CDEC8_SINGLE_STEP_EN
      if (n == 1) cu.step = 1'b1;
      if (n == 2) cu.step = 1'b0;
`endif
      @(negedge clk);
      checks++;
      if (cu.state !== e.st || cu.ctrl !== e.ctrl || cu.fetch !== (e.st == 4'd1) || cu.halt !== 1'b0) begin
        errs++;
        $display("FAIL %s cyc%0d: got state=%h ctrl=%h fetch=%b halt=%b, want state=%h ctrl=%h",
                 nm, n, cu.state, cu.ctrl, cu.fetch, cu.halt, e.st, e.ctrl);
      end
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (cu.state !== end_st) begin
      errs++;
      $display("FAIL %s end: got state=%h after %0d cycles, want %h", nm, cu.state, n, end_st);
    end
  endtask
  task automatic do_reset(input string nm);
    int n = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (cu.state !== 4'd0 || cu.ctrl !== IDLE || cu.fetch !== 1'b0 || cu.halt !== 1'b0) begin
      errs++;
      $display("FAIL %s held: got state=%h ctrl=%h fetch=%b halt=%b, want 0 %h 0 0",
               nm, cu.state, cu.ctrl, cu.fetch, cu.halt, IDLE);
    end
    rst = 1'b0;
    while (n < 20 && cu.fetch !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != P || cu.fetch !== 1'b1) begin
      errs++;
      $display("FAIL %s release: fetch after %0d cycles, want %0d", nm, n, P);
    end
  endtask
  task automatic test_reset();
    do_reset("reset");
  endtask
  task automatic test_ldi();
    run(8'h10, 3'b000, "ldi_a");
    run(8'h18, 3'b111, "ldi_c");
  endtask
  task automatic test_alu();
    logic [7:0] ops[7] = '{8'h40, 8'h54, 8'h68, 8'h7C, 8'h80, 8'h44, 8'h5C};
    foreach (ops[k]) run(ops[k], 3'b000, $sformatf("alu_%h", ops[k]));
    run(8'h90, 3'b010, "cmp_a");
    run(8'h98, 3'b000, "cmp_c");
  endtask
  task automatic test_mem();
    int w0 = wr_cnt;
    run(8'h28, 3'b000, "ld_c");
    run(8'h34, 3'b000, "st_b");
    run(8'h3C, 3'b000, "st_ra3");
    checks++;
    if (wr_cnt - w0 != 2) begin
      errs++;
      $display("FAIL st_writes: got %0d write cycles, want 2", wr_cnt - w0);
    end
  endtask
  task automatic test_branch();
    logic [2:0] fl[3] = '{3'b000, 3'b010, 3'b101};
    for (int c = 0; c < 16; c++)
      foreach (fl[j]) run({4'hB, 4'(c)}, fl[j], $sformatf("bcc%0d_f%b", c, fl[j]));
  endtask
  task automatic test_back_to_back();
    run(8'hA0, 3'b000, "jmp");
    run(8'h00, 3'b000, "nop");
    run(8'hC0, 3'b000, "op_c");
    run(8'hD5, 3'b000, "op_d");
    run(8'hE0, 3'b000, "op_e");
    run(8'h14, 3'b000, "ldi_b");
    run(8'hB1, 3'b010, "bz_taken");
    run(8'hB1, 3'b000, "bz_not");
  endtask
  task automatic test_st_abort();
    int w0 = wr_cnt, n = 0;
    cu.I = 8'h34;
    while (n < 20 && cu.state !== 4'd8) begin
`ifdef CDEC8_SINGLE_STEP_EN
      cu.step = n == 1;
`endif
      @(posedge clk);
      #1;
      n++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (cu.state !== 4'd0 || cu.ctrl !== IDLE || n >= 20) begin
      errs++;
      $display("FAIL st_abort: got state=%h ctrl=%h (E0 reached after %0d), want 0 %h", cu.state, cu.ctrl, n, IDLE);
    end
    do_reset("st_abort");
    checks++;
    if (wr_cnt != w0) begin
      errs++;
      $display("FAIL st_abort_write: got %0d write cycles, want 0", wr_cnt - w0);
    end
  endtask
  task automatic test_halt();
    int bad = 0;
    run(8'hF0, 3'b000, "hlt");
    repeat (100) begin
      @(negedge clk);
      if (cu.state !== 4'hF || cu.halt !== 1'b1 || cu.ctrl !== IDLE || cu.fetch !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errs++;
      $display("FAIL halt_hold: got %0d bad cycles of 100, want 0", bad);
    end
    do_reset("after_halt");
  endtask
`ifdef CDEC8_SINGLE_STEP_EN
  task automatic test_step();
    cu.I = 8'h00;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (cu.state !== 4'd4) begin
      errs++;
      $display("FAIL step_stall: got state=%h, want 4", cu.state);
    end
    cu.step = 1'b1;
    @(posedge clk);
    #1;
    cu.step = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (cu.state !== 4'd1) begin
      errs++;
      $display("FAIL step_go: got state=%h, want 1", cu.state);
    end
  endtask
`endif
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    cu.I = 8'h00;
    cu.SZCy = 3'b000;
`ifdef CDEC8_SINGLE_STEP_EN
    cu.step = 1'b0;
`endif
    test_reset();
    test_ldi();
    test_alu();
    test_mem();
    test_branch();
    test_back_to_back();
`ifdef CDEC8_SINGLE_STEP_EN
    test_step();
`endif
    test_st_abort();
    test_halt();
    run(8'h10, 3'b000, "ldi_after_reset");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
